// File: rtl/writeback_stage_if.sv
// Memory-stage to write-back bundle plus decode read ports and forwarding triple.
// master drives the memory-stage results and read addresses; slave is the write-back stage.
interface writeback_stage_if #(
    parameter int Width       = 32,
    parameter int RegAddrBits = 5
);
    logic                   memValid;
    logic [Width-1:0]       readData;
    logic [Width-1:0]       Aluresult;
    logic [2:0]             controlsignal0;
    logic [RegAddrBits-1:0] rd;
    logic [RegAddrBits-1:0] readReg1;
    logic [RegAddrBits-1:0] readReg2;
    logic [Width-1:0]       readData1;
    logic [Width-1:0]       readData2;
    logic                   wbRegWrite;
    logic [RegAddrBits-1:0] wbRd;
    logic [Width-1:0]       wbData;

    modport master (
        output memValid, readData, Aluresult, controlsignal0, rd, readReg1, readReg2,
        input  readData1, readData2, wbRegWrite, wbRd, wbData
    );

    modport slave (
        input  memValid, readData, Aluresult, controlsignal0, rd, readReg1, readReg2,
        output readData1, readData2, wbRegWrite, wbRd, wbData
    );
endinterface

// File: rtl/writeback_stage.sv
// MIPS write-back stage: MEM/WB register, result select, register file with bypass, retire count.
// Latency 1 cycle to wbData, RF written one cycle later; stall holds MEM/WB and blocks RF write and count.
module writeback_stage #(
    parameter int Width       = 32,
    parameter int RegAddrBits = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    writeback_stage_if.slave  wb,
    output logic [31:0]       instret
);
    localparam int NumRegs = 1 << RegAddrBits;

    logic                   mw_valid;
    logic                   mw_regwrite;
    logic                   mw_memtoreg;
    logic                   mw_byteload;
    logic [RegAddrBits-1:0] mw_rd;
    logic [Width-1:0]       mw_readdata;
    logic [Width-1:0]       mw_aluresult;

    logic [7:0]             byte_lane;
    logic [Width-1:0]       wb_value;
    logic                   wb_we;
    logic                   rf_write;
    logic [Width-1:0]       regs [NumRegs];

    always_ff @(posedge clk) begin
        if (reset) begin
            mw_valid     <= 1'b0;
            mw_regwrite  <= 1'b0;
            mw_memtoreg  <= 1'b0;
            mw_byteload  <= 1'b0;
            mw_rd        <= '0;
            mw_readdata  <= '0;
            mw_aluresult <= '0;
        end else if (flush) begin
            mw_valid    <= 1'b0;
            mw_regwrite <= 1'b0;
        end else if (!stall) begin
            mw_valid     <= wb.memValid;
            mw_regwrite  <= wb.controlsignal0[2] & wb.memValid;
            mw_memtoreg  <= wb.controlsignal0[1];
            mw_byteload  <= wb.controlsignal0[0];
            mw_rd        <= wb.rd;
            mw_readdata  <= wb.readData;
            mw_aluresult <= wb.Aluresult;
        end
    end

    // Little-endian byte lane chosen by the low address bits of the ALU result.
    always_comb begin
        byte_lane = mw_readdata[7:0];
        case (mw_aluresult[1:0])
            2'd1:    byte_lane = mw_readdata[15:8];
            2'd2:    byte_lane = mw_readdata[23:16];
            2'd3:    byte_lane = mw_readdata[31:24];
            default: byte_lane = mw_readdata[7:0];
        endcase
    end

    always_comb begin
        wb_value = mw_aluresult;
        if (mw_memtoreg) begin
            if (mw_byteload) begin
                wb_value = {{(Width-8){byte_lane[7]}}, byte_lane};
            end else begin
                wb_value = mw_readdata;
            end
        end
    end

    assign wb_we         = mw_regwrite & mw_valid & (mw_rd != '0);
    assign rf_write      = wb_we & ~stall;
    assign wb.wbRegWrite = wb_we;
    assign wb.wbRd       = mw_rd;
    assign wb.wbData     = wb_value;

    // Entry 0 is never written because wb_we excludes rd==0.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NumRegs; i++) begin
                regs[i] <= '0;
            end
        end else if (rf_write) begin
            regs[mw_rd] <= wb_value;
        end
    end

    assign wb.readData1 = (wb.readReg1 == '0) ? '0 :
                          (rf_write && (wb.readReg1 == mw_rd)) ? wb_value : regs[wb.readReg1];
    assign wb.readData2 = (wb.readReg2 == '0) ? '0 :
                          (rf_write && (wb.readReg2 == mw_rd)) ? wb_value : regs[wb.readReg2];

    always_ff @(posedge clk) begin
        if (reset) begin
            instret <= 32'd0;
        end else if (mw_valid && !stall) begin
            instret <= instret + 32'd1;
        end
    end
endmodule

// File: tb/tb_writeback_stage.sv
// Directed and random stimulus for writeback_stage against a transaction-level reference model.
module tb_writeback_stage;
    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        flush;
    logic [31:0] instret;

    always #5 clk = ~clk;

    writeback_stage_if wbif ();

    writeback_stage dut (
        .clk     (clk),
        .reset   (reset),
        .stall   (stall),
        .flush   (flush),
        .wb      (wbif),
        .instret (instret)
    );

    typedef struct {
        bit        valid;
        bit        rw;
        bit        m2r;
        bit        bl;
        bit [4:0]  rd;
        bit [31:0] rdata;
        bit [31:0] alu;
    } ent_t;

    ent_t      m;
    bit [31:0] mrf [32];
    bit [31:0] mcnt;
    int        vectors = 0;
    int        miscompares = 0;
    bit [31:0] exp_b [4];

    function automatic bit [31:0] wb_val(input ent_t e);
        bit [31:0] sh;
        bit [7:0]  b;
        if (!e.m2r) return e.alu;
        if (!e.bl) return e.rdata;
        sh = e.rdata >> (8 * int'(e.alu[1:0]));
        b  = sh[7:0];
        return {{24{b[7]}}, b};
    endfunction

    function automatic bit wb_we();
        return m.valid && m.rw && (m.rd != 5'd0);
    endfunction

    function automatic bit [31:0] rd_exp(input bit [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (a == m.rd && wb_we() && !stall) return wb_val(m);
        return mrf[a];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("wbRegWrite", 32'(wbif.wbRegWrite), 32'(wb_we()));
        chk("wbRd",       32'(wbif.wbRd),       32'(m.rd));
        chk("wbData",     wbif.wbData,          wb_val(m));
        chk("readData1",  wbif.readData1,       rd_exp(wbif.readReg1));
        chk("readData2",  wbif.readData2,       rd_exp(wbif.readReg2));
        chk("instret",    instret,              mcnt);
    endtask

    task automatic model_edge();
        if (reset) begin
            m = '{default: '0};
            foreach (mrf[i]) mrf[i] = 32'd0;
            mcnt = 32'd0;
        end else begin
            if (!stall && wb_we()) mrf[m.rd] = wb_val(m);
            if (!stall && m.valid) mcnt = mcnt + 32'd1;
            if (flush) begin
                m.valid = 1'b0;
                m.rw    = 1'b0;
            end else if (!stall) begin
                m.valid = wbif.memValid;
                m.rw    = wbif.controlsignal0[2] & wbif.memValid;
                m.m2r   = wbif.controlsignal0[1];
                m.bl    = wbif.controlsignal0[0];
                m.rd    = wbif.rd;
                m.rdata = wbif.readData;
                m.alu   = wbif.Aluresult;
            end
        end
    endtask

    task automatic tick();
        #1 check_all();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    initial begin
        exp_b[0] = 32'h0000_0001;
        exp_b[1] = 32'h0000_007F;
        exp_b[2] = 32'hFFFF_FFFF;
        exp_b[3] = 32'hFFFF_FF80;

        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        wbif.memValid = 1'b1; wbif.controlsignal0 = 3'b100; wbif.rd = 5'd3;
        wbif.readData = 32'd0; wbif.Aluresult = 32'h55;
        wbif.readReg1 = 5'd0; wbif.readReg2 = 5'd0;

        // Two reset edges with a live write pending at the inputs
        @(negedge clk);
        @(posedge clk); model_edge(); @(negedge clk);
        @(posedge clk); model_edge(); @(negedge clk);
        #1 chk("reset_instret", instret, 32'd0);
        chk("reset_wbRegWrite", 32'(wbif.wbRegWrite), 32'd0);
        chk("reset_wbData", wbif.wbData, 32'd0);
        for (int i = 0; i < 32; i++) begin
            wbif.readReg1 = 5'(i);
            wbif.readReg2 = 5'(31 - i);
            #1 chk("reset_rf1", wbif.readData1, 32'd0);
            chk("reset_rf2", wbif.readData2, 32'd0);
            @(negedge clk);
        end

        // ALU result write with same-cycle bypass then RF read
        reset = 1'b0;
        wbif.memValid = 1'b1; wbif.Aluresult = 32'h1234_5678; wbif.rd = 5'd5;
        wbif.controlsignal0 = 3'b100; wbif.readReg1 = 5'd5;
        tick();
        #1 chk("alu_wbdata", wbif.wbData, 32'h1234_5678);
        chk("alu_bypass", wbif.readData1, 32'h1234_5678);
        wbif.memValid = 1'b0;
        tick();
        tick();
        #1 chk("alu_rf", wbif.readData1, 32'h1234_5678);
        chk("alu_instret", instret, 32'd1);

        // Sign-extended byte loads across all four lanes
        wbif.memValid = 1'b1; wbif.readData = 32'h80FF_7F01;
        wbif.controlsignal0 = 3'b111; wbif.rd = 5'd10; wbif.readReg1 = 5'd10;
        for (int k = 0; k < 4; k++) begin
            wbif.Aluresult = 32'h0000_4000 | 32'(k);
            tick();
            #1 chk("byte_load", wbif.wbData, exp_b[k]);
        end

        // Destination r0 is never writable
        wbif.rd = 5'd0; wbif.controlsignal0 = 3'b100; wbif.Aluresult = 32'hDEAD_BEEF;
        wbif.readReg2 = 5'd0;
        tick();
        #1 chk("r0_we", 32'(wbif.wbRegWrite), 32'd0);
        chk("r0_read", wbif.readData2, 32'd0);
        tick();

        // Stall holds, then stall+flush drops the held instruction
        wbif.rd = 5'd7; wbif.Aluresult = 32'h0000_00A5; wbif.readReg1 = 5'd7;
        tick();
        stall = 1'b1; wbif.rd = 5'd9; wbif.Aluresult = 32'h777;
        repeat (3) begin
            tick();
            #1 chk("stall_hold", wbif.wbData, 32'h0000_00A5);
        end
        flush = 1'b1;
        tick();
        #1 chk("flush_we", 32'(wbif.wbRegWrite), 32'd0);
        flush = 1'b0; stall = 1'b0; wbif.memValid = 1'b0;
        tick();
        #1 chk("flush_r7", wbif.readData1, 32'd0);

        // Counter wrap from all-ones
        wbif.memValid = 1'b1; wbif.rd = 5'd12; wbif.Aluresult = 32'd1;
        tick();
        force dut.instret = 32'hFFFF_FFFF;
        #1 release dut.instret;
        mcnt = 32'hFFFF_FFFF;
        wbif.memValid = 1'b0;
        tick();
        #1 chk("instret_wrap", instret, 32'd0);

        repeat (800) begin
            reset = ($urandom_range(0, 99) < 2);
            stall = ($urandom_range(0, 99) < 15);
            flush = ($urandom_range(0, 99) < 10);
            wbif.memValid       = ($urandom_range(0, 99) < 80);
            wbif.readData       = $urandom;
            wbif.Aluresult      = $urandom;
            wbif.controlsignal0 = 3'($urandom_range(0, 7));
            wbif.rd             = 5'($urandom_range(0, 7));
            wbif.readReg1       = ($urandom_range(0, 1) == 0) ? m.rd : 5'($urandom_range(0, 31));
            wbif.readReg2       = 5'($urandom_range(0, 7));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
